// File: rtl/reg_bridge_pkg.sv
// Shared types and helpers for the APB-to-register-file bridge.
//   state_e  : bridge FSM states
//   DEF_*    : default bus widths and register count
//   addr_ok  : true when a byte address is word aligned and inside the register map
package reg_bridge_pkg;

    localparam int unsigned DEF_ADDR_W   = 10;
    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_NUM_REGS = 4;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_RSP,
        ERR
    } state_e;

    // Word aligned and below 4*num_regs; callers zero-extend their address to 32 bits.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned num_regs);
        return (addr[1:0] == 2'b00) && (addr < 32'(4 * num_regs));
    endfunction

endpackage

// File: rtl/apb_reg_bridge.sv
// APB3 slave front-end for the 32-bit register file.
// Turns an APB setup/access pair into one-cycle wr_en/rd_en strobes, returns the
// register file's registered rdata on prdata, and answers bad addresses with pslverr.
//   clk, rst            : clock, async active-high reset
//   psel/penable/pwrite : APB control
//   paddr/pwdata        : APB address / write data (latched in setup phase)
//   prdata/pready/pslverr : APB response (prdata combinational from reg_rdata)
//   reg_wr_en/reg_rd_en/reg_addr/reg_wdata : register file request
//   reg_rdata           : register file read data, one cycle after reg_rd_en
module apb_reg_bridge
    import reg_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata
);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              wr_en_d;
    logic              rd_en_d;
    logic              pready_d;
    logic              pslverr_d;

    // Next state plus next values of every registered output.
    always_comb begin
        state_d   = state_q;
        addr_d    = reg_addr;
        wdata_d   = reg_wdata;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;

        case (state_q)
            IDLE: begin
                // Only a true setup phase starts a transfer; a stray penable is ignored.
                if (psel && !penable) begin
                    addr_d  = paddr;
                    wdata_d = pwdata;
                    if (!addr_ok(32'(paddr), NUM_REGS)) begin
                        state_d = ERR;
                    end else if (pwrite) begin
                        state_d = WR;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            // Master dropping psel abandons the read before the response cycle.
            RD_REQ:  state_d = psel ? RD_RSP : IDLE;
            WR:      state_d = IDLE;
            RD_RSP:  state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are a registered function of the state being entered.
        wr_en_d   = (state_d == WR);
        rd_en_d   = (state_d == RD_REQ);
        pready_d  = (state_d == WR) || (state_d == RD_RSP) || (state_d == ERR);
        pslverr_d = (state_d == ERR);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
        end else begin
            state_q   <= state_d;
            reg_addr  <= addr_d;
            reg_wdata <= wdata_d;
            reg_wr_en <= wr_en_d;
            reg_rd_en <= rd_en_d;
            pready    <= pready_d;
            pslverr   <= pslverr_d;
        end
    end

    // Read data passes straight through only in the response cycle.
    assign prdata = (state_q == RD_RSP) ? reg_rdata : '0;

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Self-checking bench for apb_reg_bridge with a behavioural register file behind it.
module tb_apb_reg_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [9:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [9:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata = 32'h0;

    int checks    = 0;
    int errors    = 0;
    int wr_pulses = 0;
    int cyc       = 0;

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          waits;
    } vec_t;

    typedef struct {
        logic        wr;
        logic        err;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[10];

    logic [31:0] mem [4] = '{default: 32'h0};

    apb_reg_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .reg_wr_en (reg_wr_en),
        .reg_rd_en (reg_rd_en),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Register file model: synchronous write, registered read data.
    always @(posedge clk) begin
        if (reg_wr_en && reg_addr < 10'h010) mem[reg_addr[3:2]] <= reg_wdata;
        if (reg_rd_en) reg_rdata <= mem[reg_addr[3:2]];
    end

    // Per-cycle protocol checks.
    always @(negedge clk) begin
        if (reg_wr_en) wr_pulses++;
        checks++;
        if (reg_wr_en && reg_rd_en) begin
            errors++;
            $display("FAIL both_strobes: wr_en=%0b rd_en=%0b required not both", reg_wr_en, reg_rd_en);
        end
        checks++;
        if (pslverr && !pready) begin
            errors++;
            $display("FAIL pslverr_without_pready: pslverr=%0b pready=%0b", pslverr, pready);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One APB transfer; entered and left one time unit after a rising edge with the DUT idle.
    task automatic apb_xfer(input vec_t v);
        exp_t e;
        int   waits;
        e.wr    = v.wr;
        e.err   = v.err;
        e.rdata = v.rdata;
        e.waits = v.waits;
        sb_q.push_back(e);

        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = v.wr;
        paddr   = v.addr;
        pwdata  = v.wdata;
        @(posedge clk); #1;

        penable = 1'b1;
        paddr   = ~v.addr;
        pwdata  = ~v.wdata;
        check("t1_reg_addr", 32'(reg_addr), 32'(v.addr));
        check("t1_wr_en", 32'(reg_wr_en), 32'(v.wr && !v.err));
        check("t1_rd_en", 32'(reg_rd_en), 32'(!v.wr && !v.err));
        if (v.wr && !v.err) check("t1_reg_wdata", reg_wdata, v.wdata);

        waits = 0;
        while (!pready && waits < 8) begin
            @(posedge clk); #1;
            waits++;
        end

        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("done_pready", 32'(pready), 32'd1);
            check("done_pslverr", 32'(pslverr), 32'(e.err));
            check("done_prdata", prdata, (!e.wr && !e.err) ? e.rdata : 32'h0);
            check("done_waits", 32'(waits), 32'(e.waits));
        end

        @(posedge clk); #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        int start_cyc;
        vec_t v;

        vecs[0] = '{1'b1, 10'h000, 32'hF0F0F0F0, 1'b0, 32'h0,         0};
        vecs[1] = '{1'b0, 10'h000, 32'h0,         1'b0, 32'hF0F0F0F0, 1};
        vecs[2] = '{1'b1, 10'h006, 32'hBAD0BAD0, 1'b1, 32'h0,         0};
        vecs[3] = '{1'b0, 10'h00F, 32'h0,         1'b1, 32'h0,         0};
        vecs[4] = '{1'b1, 10'h010, 32'hBAD1BAD1, 1'b1, 32'h0,         0};
        vecs[5] = '{1'b0, 10'h010, 32'h0,         1'b1, 32'h0,         0};
        vecs[6] = '{1'b0, 10'h000, 32'h0,         1'b0, 32'hF0F0F0F0, 1};
        vecs[7] = '{1'b1, 10'h00C, 32'hA5A55A5A, 1'b0, 32'h0,         0};
        vecs[8] = '{1'b0, 10'h00C, 32'h0,         1'b0, 32'hA5A55A5A, 1};
        vecs[9] = '{1'b1, 10'h3FC, 32'hBAD2BAD2, 1'b1, 32'h0,         0};

        // Reset held while a write setup is presented.
        rst     = 1'b1;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 10'h000;
        pwdata  = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        check("rst_wr_en", 32'(reg_wr_en), 32'd0);
        check("rst_rd_en", 32'(reg_rd_en), 32'd0);
        check("rst_reg_addr", 32'(reg_addr), 32'd0);
        check("rst_reg_wdata", reg_wdata, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        psel   = 1'b0;
        pwrite = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_pready", 32'(pready), 32'd0);
        check("rst_no_wr_pulse", 32'(wr_pulses), 32'd0);

        // Table of single transfers, each followed by an idle cycle.
        for (int i = 0; i < 10; i++) begin
            apb_xfer(vecs[i]);
            check($sformatf("idle_after_%0d", i), 32'({pready, reg_wr_en, reg_rd_en}), 32'd0);
        end
        check("table_wr_pulses", 32'(wr_pulses), 32'd2);

        // Back-to-back write then read: 2 + 3 cycles, no bubble.
        start_cyc = cyc;
        v = '{1'b1, 10'h008, 32'h15975312, 1'b0, 32'h0, 0};
        apb_xfer(v);
        v = '{1'b0, 10'h008, 32'h0, 1'b0, 32'h15975312, 1};
        apb_xfer(v);
        check("b2b_cycles", 32'(cyc - start_cyc), 32'd5);

        // Abort: psel dropped during the read request cycle.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 10'h004;
        @(posedge clk); #1;
        check("abort_t1_rd_en", 32'(reg_rd_en), 32'd1);
        check("abort_t1_pready", 32'(pready), 32'd0);
        psel = 1'b0;
        @(posedge clk); #1;
        check("abort_pready", 32'(pready), 32'd0);
        check("abort_rd_en", 32'(reg_rd_en), 32'd0);
        check("abort_prdata", prdata, 32'd0);
        @(posedge clk); #1;
        check("abort_pready_late", 32'(pready), 32'd0);

        // Reset asserted during the read request cycle.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 10'h008;
        @(posedge clk); #1;
        check("mid_rst_t1_rd_en", 32'(reg_rd_en), 32'd1);
        penable = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rd_en", 32'(reg_rd_en), 32'd0);
        check("mid_rst_pready", 32'(pready), 32'd0);
        check("mid_rst_reg_addr", 32'(reg_addr), 32'd0);
        psel = 1'b0; penable = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("after_mid_rst_pready", 32'(pready), 32'd0);
        v = '{1'b1, 10'h004, 32'h11111111, 1'b0, 32'h0, 0};
        apb_xfer(v);
        v = '{1'b0, 10'h004, 32'h0, 1'b0, 32'h11111111, 1};
        apb_xfer(v);
        check("final_wr_pulses", 32'(wr_pulses), 32'd4);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/apb_reg_bridge.md
Name: apb_reg_bridge

Overview:
- APB3 slave front-end placed directly upstream of the 32-bit register file (`register`).
- Converts APB setup/access phases into the register file's single-cycle `wr_en`/`rd_en`/`addr`/`wdata` strobes.
- Returns the register file's registered `rdata` on `prdata`, with `pready`/`pslverr` completion.
- Rejects misaligned and out-of-range addresses with `pslverr` and issues no strobe for them.

Parameters:
- ADDR_W, 10, width of paddr/reg_addr (matches register file addr).
- DATA_W, 32, width of all data buses.
- NUM_REGS, 4, number of mapped 32-bit words. Legal byte addresses are 0x0 .. 4*NUM_REGS-4, word aligned.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- psel  input  1  APB select.
- penable  input  1  APB enable (access phase).
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDR_W  APB byte address.
- pwdata  input  DATA_W  APB write data.
- prdata  output  DATA_W  APB read data, valid only while pready=1 on a read.
- pready  output  1  transfer complete.
- pslverr  output  1  error response, valid only while pready=1.
- reg_wr_en  output  1  to register file wr_en.
- reg_rd_en  output  1  to register file rd_en.
- reg_addr  output  ADDR_W  to register file addr.
- reg_wdata  output  DATA_W  to register file wdata.
- reg_rdata  input  DATA_W  from register file rdata; valid 1 cycle after reg_rd_en.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - pready, pslverr, reg_wr_en and reg_rd_en = 0.
  - reg_addr, reg_wdata and prdata = 0.
- All outputs are registered except prdata, defined as: prdata = reg_rdata when state==RD_RSP, else 0.
- Error condition is decoded in the setup phase: paddr[1:0]!=0 OR paddr >= 4*NUM_REGS.
- FSM states: IDLE, WR, RD_REQ, RD_RSP, ERR.
- IDLE:
  - On psel=1 and penable=0 (setup sampled, cycle T0), latch paddr into reg_addr and pwdata into reg_wdata.
  - If error, go to ERR.
  - Else if pwrite=1, go to WR.
  - Else go to RD_REQ.
- WR (cycle T1): reg_wr_en=1 and pready=1 for exactly this cycle. The write completes with zero wait states. Next state is IDLE.
- RD_REQ (T1): reg_rd_en=1 and pready=0. Next state is RD_RSP.
- RD_RSP (T2): pready=1 and prdata=reg_rdata; reg_rd_en=0. Next state is IDLE. A read costs one wait state.
- ERR (T1): pready=1 and pslverr=1. No reg strobe is issued. Next state is IDLE.
- pslverr=0 in every state other than ERR.
- Back-to-back transfers: a completion cycle returns to IDLE. A setup phase on the following cycle is accepted, so there are no bubbles beyond APB's mandatory setup phase.
- psel deasserted while in RD_REQ, RD_RSP or WR: abort to IDLE on the next edge with all strobes 0. A write already strobed stays committed.
- penable=1 observed in IDLE (no setup phase): ignored, no strobe, stays in IDLE.
- pwdata/paddr changes during the access phase are ignored; the values latched at T0 are used.
- Never assert reg_wr_en and reg_rd_en in the same cycle.
- Async reset mid-transfer: outputs drop immediately and no completion is signalled.

Decomposition:
- Shared package (reg_bridge_pkg): state enum (IDLE, WR, RD_REQ, RD_RSP, ERR), default ADDR_W/DATA_W/NUM_REGS, and the address-check function (aligned and in-range).
- No sub-module. The address decoder is a function, and the FSM plus output registers form one module.

Test Plan:
1. Reset with rst=1 while psel=1 and pwrite=1 -> all outputs 0 and no reg_wr_en pulse. After release, IDLE with pready=0.
2. Write paddr=0x0, pwdata=0xF0F0F0F0 -> reg_wr_en high 1 cycle at T1 with reg_addr=0x0 and reg_wdata=0xF0F0F0F0. pready=1 and pslverr=0 at T1.
3. Read paddr=0x0 after test 2 -> reg_rd_en at T1, pready=0. At T2, pready=1 and prdata=0xF0F0F0F0.
4. Write 0x8 with 0x15975312, then an immediate back-to-back read of 0x8 -> the read setup is accepted the cycle after the write completes, and prdata=0x15975312. The transfer sequence is exactly 2+3 cycles.
5. Error responses, misaligned paddr=0x6 and out-of-range paddr=0xF/0x10:
   - Both return pready=1 and pslverr=1 at T1, with no reg strobe.
   - A follow-up read of 0x0 still returns its prior value.
6. Abort and mid-operation reset:
   - Drop psel in RD_REQ -> FSM returns to IDLE, pready never asserted.
   - Assert rst during RD_REQ -> reg_rd_en and pready drop at once. A subsequent write of 0x4=0x11111111 followed by a read returns 0x11111111.
